// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end between the imem port and decode.
// Issues sequential fetches over a ready-qualified handshake and buffers up to
// DEPTH fetched words with their PC and PC+4. A redirect flushes the queue and
// restarts fetch at a new target. A misaligned target becomes one fault entry
// and fetch halts until the next redirect.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   redirect_valid/pc          flush and restart fetch at redirect_pc
//   imem_req/addr              fetch request and address (addr = fetch_pc)
//   imem_data/ready            fetched word, valid in the cycle ready=1
//   out_valid/deq_ready        head-of-queue handshake towards decode
//   out_pc/pc4/inst/fault      head entry, forced to 0 when out_valid=0
//   count, buf_empty, buf_full occupancy status
module fetch_queue #(
   parameter int unsigned            ADDR_WIDTH = 64,
   parameter int unsigned            INST_WIDTH = 32,
   parameter int unsigned            DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       redirect_valid,
   input  logic [ADDR_WIDTH-1:0]      redirect_pc,
   output logic                       imem_req,
   output logic [ADDR_WIDTH-1:0]      imem_addr,
   input  logic [INST_WIDTH-1:0]      imem_data,
   input  logic                       imem_ready,
   output logic                       out_valid,
   input  logic                       deq_ready,
   output logic [ADDR_WIDTH-1:0]      out_pc,
   output logic [ADDR_WIDTH-1:0]      out_pc4,
   output logic [INST_WIDTH-1:0]      out_inst,
   output logic                       out_fault,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       buf_empty,
   output logic                       buf_full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // Entry storage
   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
   logic [ADDR_WIDTH-1:0] pc4_mem  [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem [DEPTH];
   logic                  fault_mem[DEPTH];

   // Control state
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  fault_pending_q, fault_pending_d;
   logic                  halted_q, halted_d;

   logic                  accept_c;
   logic                  fault_push_c;
   logic                  push_c;
   logic                  pop_c;
   logic [ADDR_WIDTH-1:0] fetch_pc4_c;
   logic [INST_WIDTH-1:0] wr_inst_c;

   // Request issue and handshake qualification
   always_comb begin
      imem_req     = !reset && (count_q < CNT_W'(DEPTH)) && !halted_q && !fault_pending_q;
      imem_addr    = fetch_pc_q;
      out_valid    = (count_q != '0);
      accept_c     = imem_req && imem_ready && !redirect_valid;
      // A pending fault never coincides with a request, so the pushes are exclusive.
      fault_push_c = fault_pending_q && !redirect_valid && !reset;
      push_c       = accept_c || fault_push_c;
      pop_c        = out_valid && deq_ready && !redirect_valid;
      fetch_pc4_c  = fetch_pc_q + ADDR_WIDTH'(4);
      wr_inst_c    = fault_push_c ? '0 : imem_data;
   end

   // Head and status outputs
   always_comb begin
      out_pc    = '0;
      out_pc4   = '0;
      out_inst  = '0;
      out_fault = 1'b0;
      if (out_valid) begin
         out_pc    = pc_mem[rd_ptr_q];
         out_pc4   = pc4_mem[rd_ptr_q];
         out_inst  = inst_mem[rd_ptr_q];
         out_fault = fault_mem[rd_ptr_q];
      end
      count     = count_q;
      buf_empty = (count_q == '0);
      buf_full  = (count_q == CNT_W'(DEPTH));
   end

   // Next-state logic; redirect outranks push and pop
   always_comb begin
      fetch_pc_d      = fetch_pc_q;
      rd_ptr_d        = rd_ptr_q;
      wr_ptr_d        = wr_ptr_q;
      count_d         = count_q;
      fault_pending_d = fault_pending_q;
      halted_d        = halted_q;
      if (redirect_valid) begin
         fetch_pc_d      = redirect_pc;
         rd_ptr_d        = '0;
         wr_ptr_d        = '0;
         count_d         = '0;
         halted_d        = 1'b0;
         fault_pending_d = (redirect_pc[1:0] != 2'b00);
      end else begin
         if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (accept_c) begin
            fetch_pc_d = fetch_pc4_c;
         end
         if (fault_push_c) begin
            fault_pending_d = 1'b0;
            halted_d        = 1'b1;
         end
      end
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q      <= RESET_PC;
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         count_q         <= '0;
         fault_pending_q <= 1'b0;
         halted_q        <= 1'b0;
      end else begin
         fetch_pc_q      <= fetch_pc_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         count_q         <= count_d;
         fault_pending_q <= fault_pending_d;
         halted_q        <= halted_d;
      end
   end

   // Entry write; payload storage needs no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (push_c && !reset) begin
         pc_mem[wr_ptr_q]    <= fetch_pc_q;
         pc4_mem[wr_ptr_q]   <= fetch_pc4_c;
         inst_mem[wr_ptr_q]  <= wr_inst_c;
         fault_mem[wr_ptr_q] <= fault_push_c;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model and a scoreboard of head entries.
module tb_fetch_queue;

   localparam logic [63:0] RST_PC = 64'h100;
   localparam int          DEP    = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic [31:0] imem_data = '0;
   logic        imem_ready = 1'b0;
   logic        out_valid;
   logic        deq_ready = 1'b0;
   logic [63:0] out_pc;
   logic [63:0] out_pc4;
   logic [31:0] out_inst;
   logic        out_fault;
   logic [2:0]  count;
   logic        buf_empty;
   logic        buf_full;

   fetch_queue #(
      .ADDR_WIDTH(64), .INST_WIDTH(32), .DEPTH(DEP), .RESET_PC(RST_PC)
   ) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_data(imem_data), .imem_ready(imem_ready),
      .out_valid(out_valid), .deq_ready(deq_ready),
      .out_pc(out_pc), .out_pc4(out_pc4), .out_inst(out_inst), .out_fault(out_fault),
      .count(count), .buf_empty(buf_empty), .buf_full(buf_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] pc4;
      logic [31:0] inst;
      logic        fault;
   } ent_t;

   ent_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state
   logic [63:0] m_pc   = RST_PC;
   int          m_cnt  = 0;
   bit          m_fp   = 0;
   bit          m_halt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   // One clock cycle: drive inputs, check control outputs, advance the model.
   task automatic cyc(input bit rst, input bit rv, input logic [63:0] rpc,
                      input bit rdy, input bit dq);
      bit req;
      bit pop;
      @(negedge clk);
      reset = rst; redirect_valid = rv; redirect_pc = rpc;
      imem_ready = rdy; imem_data = $urandom; deq_ready = dq;
      #1;
      req = !rst && (m_cnt < DEP) && !m_halt && !m_fp;
      chk("imem_req", 64'(imem_req), 64'(req));
      if (req) chk("imem_addr", imem_addr, m_pc);
      chk("count", 64'(count), 64'(m_cnt));
      chk("buf_empty", 64'(buf_empty), 64'(m_cnt == 0));
      chk("buf_full", 64'(buf_full), 64'(m_cnt == DEP));
      chk("out_valid", 64'(out_valid), 64'(m_cnt != 0));
      if (rst) begin
         m_pc = RST_PC; m_cnt = 0; m_fp = 0; m_halt = 0; sb.delete();
      end else if (rv) begin
         sb.delete(); m_cnt = 0; m_halt = 0; m_pc = rpc; m_fp = (rpc[1:0] != 2'b00);
      end else begin
         pop = (m_cnt > 0) && dq;
         if (m_fp) begin
            sb.push_back('{pc: m_pc, pc4: m_pc + 64'd4, inst: 32'd0, fault: 1'b1});
            m_cnt++; m_fp = 0; m_halt = 1;
         end else if (req && rdy) begin
            sb.push_back('{pc: m_pc, pc4: m_pc + 64'd4, inst: imem_data, fault: 1'b0});
            m_pc = m_pc + 64'd4; m_cnt++;
         end
         if (pop) m_cnt--;
      end
   endtask

   // Monitor: compare the head entry against the scoreboard on each dequeue
   always @(negedge clk) begin
      ent_t e;
      #2;
      if (!reset && !redirect_valid && out_valid && deq_ready) begin
         if (sb.size() == 0) begin
            chk("deq_unexpected", 64'(out_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_pc4", out_pc4, e.pc4);
            chk("out_inst", 64'(out_inst), 64'(e.inst));
            chk("out_fault", 64'(out_fault), 64'(e.fault));
         end
      end else if (!out_valid) begin
         chk("idle_head_zero", out_pc | out_pc4 | 64'(out_inst) | 64'(out_fault), 64'd0);
      end
   end

   initial begin
      logic [63:0] t;
      int          r;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 1);

      // Fill: four pushes from RESET_PC, then full with request dropped
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 1);
      chk("fill_full", 64'(buf_full), 64'd1);
      chk("fill_req_off", 64'(imem_req), 64'd0);
      chk("fill_head", out_pc, 64'h100);
      cyc(0, 0, 0, 0, 0);
      chk("after_pop_head", out_pc, 64'h104);
      chk("after_pop_req", 64'(imem_req), 64'd1);
      chk("after_pop_addr", imem_addr, 64'h110);

      // Redirect with simultaneous response and pop, three entries held
      cyc(0, 1, 64'h2000, 1, 1);
      cyc(0, 0, 0, 1, 0);
      chk("redir_flush", 64'(count), 64'd0);
      chk("redir_addr", imem_addr, 64'h2000);
      cyc(0, 0, 0, 0, 1);
      chk("redir_head", out_pc, 64'h2000);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1);

      // Misaligned redirect produces one fault entry and halts fetch
      cyc(0, 1, 64'h2002, 1, 0);
      cyc(0, 0, 0, 1, 0);
      chk("mis_req_n1", 64'(imem_req), 64'd0);
      cyc(0, 0, 0, 1, 0);
      chk("mis_valid", 64'(out_valid), 64'd1);
      chk("mis_fault", 64'(out_fault), 64'd1);
      chk("mis_pc", out_pc, 64'h2002);
      chk("mis_inst", 64'(out_inst), 64'd0);
      chk("mis_req_n2", 64'(imem_req), 64'd0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);
      chk("mis_halted", 64'(imem_req), 64'd0);
      cyc(0, 1, 64'h3000, 1, 1);
      cyc(0, 0, 0, 1, 1);
      chk("resume_req", 64'(imem_req), 64'd1);
      chk("resume_addr", imem_addr, 64'h3000);

      // Address wrap-around and pointer wrap over several fills
      cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1);
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0, 1, 1);
      chk("wrap_addr", imem_addr, 64'h0);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
         for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
      end

      // Mid-stream reset with three entries and a stalled request
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0);
      chk("rst_req_off", 64'(imem_req), 64'd0);
      cyc(0, 0, 0, 0, 0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_addr", imem_addr, RST_PC);

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 99);
         t = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       t[1:0] = 2'b01;
            1:       t = 64'hFFFF_FFFF_FFFF_FFF0;
            default: t[1:0] = 2'b00;
         endcase
         cyc(r == 0, (r >= 1) && (r <= 3), t,
             $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6);
      end
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end that replaces the fixed single-entry fetch path between the instruction memory port and the ID stage. It issues sequential fetch requests over a ready-qualified imem handshake, buffers up to DEPTH fetched words with their PC and PC+4, and presents them to decode through a valid/ready interface. It also handles redirects, which flush the queue and restart fetch at a new target, and flags misaligned targets as fault entries instead of fetching them.

## Interface
- ADDR_WIDTH, 64, PC and memory address width
- INST_WIDTH, 32, instruction word width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, fetch address after reset; must be 4-byte aligned
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc (branch, jump or trap)
- redirect_pc  in  ADDR_WIDTH  new fetch target
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_WIDTH  fetch address (equals fetch_pc)
- imem_data  in  INST_WIDTH  fetched word; valid when imem_ready=1
- imem_ready  in  1  request completed this cycle
- out_valid  out  1  head entry available to decode
- deq_ready  in  1  decode consumes the head this cycle
- out_pc  out  ADDR_WIDTH  PC of the head entry
- out_pc4  out  ADDR_WIDTH  out_pc + 4 of the head entry
- out_inst  out  INST_WIDTH  instruction word of the head entry
- out_fault  out  1  head entry is a misaligned-fetch fault
- count  out  $clog2(DEPTH)+1  current occupancy
- buf_empty  out  1  count == 0
- buf_full  out  1  count == DEPTH

## Operation
- State:
  - fetch_pc register
  - circular buffer of DEPTH entries, each {pc, pc4, inst, fault}
  - read and write pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH
  - count register
  - fault_pending register
  - halted register
- imem_req = !reset && count < DEPTH && !halted && !fault_pending. Request issue does not look ahead at a same-cycle dequeue.
- Push (accept): imem_req && imem_ready && !redirect_valid.
  - Writes {fetch_pc, fetch_pc+4, imem_data, 0} at the write pointer.
  - fetch_pc <= fetch_pc + 4. Addition wraps modulo 2^ADDR_WIDTH; pc4 wraps the same way.
- Pop: out_valid && deq_ready && !redirect_valid. Advances the read pointer.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Redirect has priority over every other event in its cycle:
  - count, read pointer and write pointer clear to 0.
  - Any same-cycle imem response is discarded; any same-cycle pop is a no-op.
  - halted clears.
  - If redirect_pc[1:0] == 0: fetch_pc <= redirect_pc, fault_pending <= 0.
  - Otherwise: fetch_pc <= redirect_pc, fault_pending <= 1.
- Fault handling:
  - fault_pending=1 and no redirect: push {redirect target, +4, inst=0, fault=1} into the (empty) queue, then fault_pending <= 0 and halted <= 1.
  - Fetch stays halted until the next redirect.
- Head outputs are combinational from the entry at the read pointer. When out_valid=0, out_pc, out_pc4, out_inst and out_fault are forced to 0.
- Reset (also mid-operation) produces, at the next edge:
  - fetch_pc=RESET_PC, count=0, pointers=0
  - fault_pending=0, halted=0
  - out_valid=0, buf_empty=1, buf_full=0, imem_req=0 during the reset cycle
- imem_ready while imem_req=0 is ignored.

## Timing
- Accept in cycle N → entry visible (out_valid=1) in cycle N+1. Sustained throughput is 1 instruction/cycle when imem_ready is held high and deq_ready=1.
- imem_addr must be held stable while imem_req=1 && imem_ready=0, unless a redirect occurs. After a redirect the new address appears the next cycle, and the memory serves whatever address is presented in the imem_ready cycle.
- Redirect in cycle N:
  - aligned target: imem_req=1 with imem_addr=redirect_pc in cycle N+1 (if the flushed count permits, which it always does).
  - misaligned target: fault entry has out_valid=1 in cycle N+2; imem_req stays 0 from N+1 onward.
- When full: imem_req drops in the cycle count reaches DEPTH and returns the cycle after the first pop.
- count, buf_empty and buf_full are registered-state derived and never show intermediate values.

## Test plan
- Reset then streaming, imem_ready=1, deq_ready=1: imem_addr 0,4,8,…; out_pc follows one cycle behind; out_pc4=out_pc+4; count stays 1.
- Fill, deq_ready=0, DEPTH=4, RESET_PC=0x100: four pushes (0x100–0x10C), buf_full=1, imem_req=0. One pop → out_pc=0x104 and imem_req=1 at address 0x110 the next cycle.
- Redirect with a simultaneous response and pop, queue holding 3 entries, redirect_pc=0x2000: queue is empty next cycle with the response discarded; imem_addr=0x2000; first out_pc=0x2000.
- Misaligned redirect to 0x2002: next-next cycle out_valid=1, out_fault=1, out_pc=0x2002, out_inst=0; imem_req stays 0. A later redirect to 0x3000 resumes fetch.
- Wrap-around, with fetch_pc near 2^ADDR_WIDTH−4 reached via redirect: the next fetch address is 0 and that entry's out_pc4 wraps; pointers wrap after 2×DEPTH pushes with data intact.
- Reset asserted mid-stream with count=3 and imem_req held waiting: next cycle count=0, out_valid=0, imem_addr=RESET_PC, and imem_req is 0 during reset.
